// File: rtl/reg_writeback_unit.sv
// Write-side driver for the integer register file: ALU results go straight to a
// registered write port, aligned/extended loads queue in a small FIFO that drains on idle slots.
module reg_writeback_unit #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [XLEN-1:0]          alu_result,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [4:0]               ld_rd,
   input  logic [XLEN-1:0]          ld_data,
   input  logic [2:0]               ld_funct3,
   input  logic [2:0]               ld_offset,
   output logic                     rf_we,
   output logic [4:0]               rf_rd,
   output logic [XLEN-1:0]          rf_wdata,
   output logic [31:0]              ld_pending,
   output logic [$clog2(DEPTH):0]   ld_count,
   output logic                     err_misalign
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   function automatic logic load_legal(input logic [2:0] f3, input logic [2:0] off);
      logic ok;
      case (f3)
         3'b000, 3'b100: ok = 1'b1;
         3'b001, 3'b101: ok = (off[0] == 1'b0);
         3'b010, 3'b110: ok = (off[1:0] == 2'b00);
         3'b011:         ok = (off == 3'b000);
         default:        ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] data,
                                                    input logic [2:0] f3,
                                                    input logic [2:0] off);
      logic [XLEN-1:0] field;
      logic [XLEN-1:0] res;
      field = data >> {off, 3'b000};
      case (f3)
         3'b000:  res = {{(XLEN-8){field[7]}}, field[7:0]};
         3'b001:  res = {{(XLEN-16){field[15]}}, field[15:0]};
         3'b010:  res = {{(XLEN-32){field[31]}}, field[31:0]};
         3'b011:  res = data;
         3'b100:  res = {{(XLEN-8){1'b0}}, field[7:0]};
         3'b101:  res = {{(XLEN-16){1'b0}}, field[15:0]};
         3'b110:  res = {{(XLEN-32){1'b0}}, field[31:0]};
         default: res = {XLEN{1'b0}};
      endcase
      return res;
   endfunction

   logic [4:0]      rd_q    [DEPTH];
   logic [4:0]      rd_d    [DEPTH];
   logic [XLEN-1:0] data_q  [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     pending_q, pending_d;
   logic            err_q, err_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

   logic            alu_wr_s, xfer_s, legal_s, push_s, pop_s;
   logic [AW-1:0]   slot_s;

   assign ld_ready     = (count_q != FULL);
   assign alu_wr_s     = alu_valid && (alu_rd != 5'd0);
   assign xfer_s       = ld_valid && ld_ready;
   assign legal_s      = load_legal(ld_funct3, ld_offset);
   assign push_s       = xfer_s && legal_s && (ld_rd != 5'd0);
   // ALU owns the write port; the FIFO head only drains in otherwise idle cycles
   assign pop_s        = (count_q != {CW{1'b0}}) && !alu_wr_s;

   assign rf_we        = rf_we_q;
   assign rf_rd        = rf_rd_q;
   assign rf_wdata     = rf_wdata_q;
   assign ld_pending   = pending_q;
   assign ld_count     = count_q;
   assign err_misalign = err_q;

   // Next FIFO state, pending mask derived from the post-update contents, and write-port selection
   always_comb begin
      rd_d       = rd_q;
      slot_s     = {AW{1'b0}};
      pending_d  = 32'd0;
      err_d      = err_q | (xfer_s && !legal_s);
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;

      if (push_s) begin
         rd_d[wr_ptr_q] = ld_rd;
         wr_ptr_d       = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d       = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      count_d = count_q + CW'(push_s) - CW'(pop_s);

      for (int i = 0; i < DEPTH; i++) begin
         slot_s    = AW'(i) - rd_ptr_d;
         pending_d = pending_d |
                     (({1'b0, slot_s} < count_d) ? (32'd1 << rd_d[i]) : 32'd0);
      end
      pending_d[0] = 1'b0;

      if (alu_wr_s) begin
         rf_we_d    = 1'b1;
         rf_rd_d    = alu_rd;
         rf_wdata_d = alu_result;
      end else if (pop_s) begin
         rf_we_d    = 1'b1;
         rf_rd_d    = rd_q[rd_ptr_q];
         rf_wdata_d = data_q[rd_ptr_q];
      end else begin
         rf_we_d    = 1'b0;
      end
   end

   // State update; reset drops queued entries and overrides any same-cycle transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i] <= 5'd0;
         end
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         pending_q  <= 32'd0;
         err_q      <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= {XLEN{1'b0}};
      end else begin
         rd_q       <= rd_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pending_q  <= pending_d;
         err_q      <= err_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         if (push_s) begin
            data_q[wr_ptr_q] <= load_extract(ld_data, ld_funct3, ld_offset);
         end else begin
            data_q[wr_ptr_q] <= data_q[wr_ptr_q];
         end
      end
   end

endmodule
